// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control path.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] FUNCT_CMP = 4'b1010;

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module mc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mc_main_fsm.sv
// Main sequencer for the multicycle ARMv4-subset core with
// memory wait states and a retired-instruction count.
module mc_main_fsm
  import arm_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       rd,
  input  logic             cond_ex,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             ir_write,
  output logic             adr_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             alu_op,
  output logic             reg_write,
  output logic             mem_write,
  output logic             pc_write,
  output logic             flag_write,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e state_q, state_d;
  logic   cond_q, cond_d;
  logic   retire;
  logic   is_cmp;
  logic   rd_pc;

  assign is_cmp = (funct[4:1] == FUNCT_CMP);
  assign rd_pc  = (rd == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_WD;
    result_src = RES_ALUOUT;
    alu_op     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    flag_write = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        cond_d     = cond_ex;
        if (!cond_ex) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          unique case (1'b1)
            (op == OP_DP) &&  funct[5]: state_d = S_EXECI;
            (op == OP_DP) && !funct[5]: state_d = S_EXECR;
            (op == OP_MEM):             state_d = S_MEMADR;
            (op == OP_BR):              state_d = S_BRANCH;
            default: begin
              state_d = S_FETCH;
              illegal = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = cond_q;
        pc_write   = cond_q & rd_pc;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = cond_q;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_b  = (state_q == S_EXECI) ? SRCB_IMM : SRCB_WD;
        alu_op     = 1'b1;
        flag_write = cond_q;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = cond_q & ~is_cmp;
        pc_write  = cond_q & rd_pc & ~is_cmp;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write   = cond_q;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire (
    .clk  (clk),
    .reset(reset),
    .inc_i(retire),
    .cnt_o(retired)
  );

endmodule

// File: tb/tb_mc_main_fsm.sv
// Instruction-level reference bench for mc_main_fsm with random
// instruction mix, wait states and an asynchronous mid-write reset.
module tb_mc_main_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        cond_ex;
  logic        mem_ready;
  logic        mem_req, ir_write, adr_src, alu_src_a;
  logic [1:0]  alu_src_b, result_src;
  logic        alu_op, reg_write, mem_write, pc_write;
  logic        flag_write, illegal;
  logic [31:0] retired;

  mc_main_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .cond_ex(cond_ex), .mem_ready(mem_ready), .mem_req(mem_req),
    .ir_write(ir_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .reg_write(reg_write), .mem_write(mem_write), .pc_write(pc_write),
    .flag_write(flag_write), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mr;
    logic        dec;
    logic        ret;
    logic [13:0] ctl;
  } step_t;

  step_t       q[$];
  logic [13:0] got;
  logic [13:0] exp_ctl;
  logic [31:0] exp_ret;
  logic        chk_en = 1'b0;
  int          model_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  assign got = {mem_req, ir_write, adr_src, alu_src_a, alu_src_b,
                result_src, alu_op, reg_write, mem_write, pc_write,
                flag_write, illegal};

  function automatic logic [13:0] ctl(
    input logic req, irw, adr, asa,
    input logic [1:0] asb, rs,
    input logic aop, rw, mw, pw, fw, ill);
    return {req, irw, adr, asa, asb, rs, aop, rw, mw, pw, fw, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] w);
    n_chk++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, g, w);
    end
  endtask

  task automatic push(input logic mr, dec, ret, input logic [13:0] c);
    step_t s;
    s.mr = mr; s.dec = dec; s.ret = ret; s.ctl = c;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle control for one instruction.
  task automatic build(input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic c,
                       input int fw, input int mw);
    logic any, cmp, pc15;
    cmp  = (f[4:1] == 4'b1010);
    pc15 = (r == 4'd15);
    q.delete();
    for (int i = 0; i < fw; i++)
      push(1'b0, 1'b0, 1'b0, ctl(1,0,0,1,2'b10,2'b10,0,0,0,0,0,0));
    push(1'b1, 1'b0, 1'b0, ctl(1,1,0,1,2'b10,2'b10,0,0,0,1,0,0));
    any = 1'($urandom % 2);
    push(any, 1'b1, !c,
         ctl(0,0,0,1,2'b10,2'b10,0,0,0,0,0,c && o == 2'b11));
    if (!c || o == 2'b11) return;
    any = 1'($urandom % 2);
    if (o == 2'b00) begin
      push(any, 1'b0, 1'b0,
           ctl(0,0,0,0,{1'b0, f[5]},2'b00,1,0,0,0,1,0));
      any = 1'($urandom % 2);
      push(any, 1'b0, 1'b1,
           ctl(0,0,0,0,2'b00,2'b00,0,!cmp,0,!cmp && pc15,0,0));
    end else if (o == 2'b10) begin
      push(any, 1'b0, 1'b1, ctl(0,0,0,0,2'b01,2'b10,0,0,0,1,0,0));
    end else begin
      push(any, 1'b0, 1'b0, ctl(0,0,0,0,2'b01,2'b00,0,0,0,0,0,0));
      for (int i = 0; i <= mw; i++)
        push(i == mw, 1'b0, !f[0] && i == mw,
             ctl(1,0,1,0,2'b00,2'b00,0,0,!f[0],0,0,0));
      if (f[0]) begin
        any = 1'($urandom % 2);
        push(any, 1'b0, 1'b1,
             ctl(0,0,0,0,2'b00,2'b01,0,1,0,pc15,0,0));
      end
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic c,
                       input int upto);
    for (int i = 0; i < upto; i++) begin
      @(negedge clk);
      op        = o;
      funct     = f;
      rd        = r;
      mem_ready = q[i].mr;
      cond_ex   = q[i].dec ? c : 1'($urandom % 2);
      exp_ctl   = q[i].ctl;
      exp_ret   = 32'(model_cnt);
      chk_en    = 1'b1;
      if (q[i].ret) model_cnt++;
    end
  endtask

  task automatic instr(input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic c,
                       input int fw, input int mw);
    build(o, f, r, c, fw, mw);
    drive(o, f, r, c, q.size());
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("ctl", 32'(got), 32'(exp_ctl));
      chk("retired", retired, exp_ret);
    end
  end

  localparam logic [13:0] FETCH_IDLE =
    {1'b1,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

  initial begin
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] r;
    logic       c;

    reset = 1'b1; mem_ready = 1'b0; cond_ex = 1'b0;
    op = 2'b00; funct = 6'd0; rd = 4'd0;
    #1;
    chk("reset_ctl", 32'(got), 32'(FETCH_IDLE));
    chk("reset_retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    build(2'b00, 6'b101000, 4'd1, 1'b1, 0, 0);
    chk("lat_dp", q.size(), 4);
    build(2'b01, 6'b000001, 4'd1, 1'b1, 0, 0);
    chk("lat_ldr", q.size(), 5);
    build(2'b01, 6'b000000, 4'd1, 1'b1, 0, 0);
    chk("lat_str", q.size(), 4);
    build(2'b10, 6'b000000, 4'd1, 1'b1, 0, 0);
    chk("lat_b", q.size(), 3);
    build(2'b01, 6'b000000, 4'd1, 1'b0, 0, 0);
    chk("lat_skip", q.size(), 2);
    build(2'b01, 6'b000001, 4'd1, 1'b1, 0, 2);
    chk("lat_ldr_wait2", q.size(), 7);

    instr(2'b00, 6'b101000, 4'd2, 1'b1, 0, 0);
    @(posedge clk); #1;
    chk("add_retired", retired, 32'd1);
    instr(2'b01, 6'b011001, 4'd3, 1'b1, 0, 2);
    instr(2'b01, 6'b011000, 4'd3, 1'b0, 0, 0);
    instr(2'b00, 6'b010101, 4'd15, 1'b1, 0, 0);
    instr(2'b10, 6'b000000, 4'd0, 1'b1, 0, 0);
    instr(2'b11, 6'b000000, 4'd0, 1'b1, 0, 0);
    instr(2'b00, 6'b001000, 4'd15, 1'b1, 1, 0);
    instr(2'b01, 6'b000001, 4'd15, 1'b1, 2, 1);
    @(posedge clk); #1;
    chk("directed_retired", retired, 32'd7);

    for (int n = 0; n < 300; n++) begin
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      if ($urandom % 4 == 0) f[4:1] = 4'b1010;
      r = ($urandom % 3 == 0) ? 4'd15 : 4'($urandom);
      c = ($urandom % 5) != 0;
      instr(o, f, r, c, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    build(2'b01, 6'b000000, 4'd4, 1'b1, 0, 3);
    drive(2'b01, 6'b000000, 4'd4, 1'b1, 4);
    #3;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_ctl", 32'(got), 32'(FETCH_IDLE));
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    instr(2'b00, 6'b100100, 4'd5, 1'b1, 0, 0);
    @(posedge clk); #1;
    chk("post_rst_retired", retired, 32'd1);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Main sequencing state machine for the multicycle ARMv4-subset core, the next step after the single-cycle implementation.
- Drives multiplexer selects, register/memory/PC write strobes and instruction-register load for a shared-ALU, shared-memory datapath.
- Supports:
  - DP immediate/register instructions, including CMP (no writeback) and EOR.
  - LDR and STR.
  - B.
- Adds a memory wait-state handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- op  in  2  Instr[27:26] from IR.
- funct  in  6  Instr[25:20] from IR.
- rd  in  4  Instr[15:12] from IR.
- cond_ex  in  1  condition-pass from external condcheck; sampled in DECODE only.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access active.
- ir_write  out  1  load IR.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- alu_src_a  out  1  0 = A reg, 1 = PC.
- alu_src_b  out  2  00 = WriteData reg, 01 = ExtImm, 10 = const 4.
- result_src  out  2  00 = ALUOut, 01 = Data reg, 10 = ALUResult.
- alu_op  out  1  1 = ALU decoder uses funct, 0 = ADD.
- reg_write  out  1  register-file write.
- mem_write  out  1  data write.
- pc_write  out  1  PC <= Result.
- flag_write  out  1  flags may update (S-bit qualified externally).
- illegal  out  1  one-cycle pulse on op = 11.
- retired  out  CNT_W  count of completed instructions, including skipped ones.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- State register is asynchronously reset to FETCH. All outputs are Moore decodes of state, plus qualified handshake terms.
- Reset values: all outputs equal FETCH decode with mem_ready = 0, i.e. mem_req = 1, alu_src_a = 1, alu_src_b = 10, result_src = 10, others 0; retired = 0.
- cond_q register: loads cond_ex in DECODE; reset 0.
- FETCH:
  - adr_src = 0, mem_req = 1, alu_src_a = 1, alu_src_b = 10, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Stay while !mem_ready; -> DECODE when mem_ready.
- DECODE:
  - alu_src_a = 1, alu_src_b = 10, result_src = 10 (PC+8 for R15).
  - If !cond_ex -> FETCH and retired increments (skipped instruction).
  - Else route by op:
    - 00 with funct[5] = 1 -> EXECI.
    - 00 with funct[5] = 0 -> EXECR.
    - 01 -> MEMADR.
    - 10 -> BRANCH.
    - 11 -> FETCH with illegal = 1; retired does not increment.
- MEMADR:
  - alu_src_a = 0, alu_src_b = 01, alu_op = 0.
  - -> MEMREAD if funct[0] else MEMWRITE.
- MEMREAD:
  - adr_src = 1, mem_req = 1, result_src = 00.
  - Hold until mem_ready -> MEMWB.
- MEMWB:
  - result_src = 01, reg_write = cond_q.
  - pc_write = cond_q & (rd == 15).
  - -> FETCH, retire.
- MEMWRITE:
  - adr_src = 1, mem_req = 1, result_src = 00.
  - mem_write = cond_q, held through the wait.
  - -> FETCH on mem_ready, retire. The memory write commits on the mem_ready cycle.
- EXECR: alu_src_a = 0, alu_src_b = 00, alu_op = 1, flag_write = cond_q; -> ALUWB.
- EXECI: as EXECR with alu_src_b = 01; -> ALUWB.
- ALUWB:
  - result_src = 00.
  - reg_write = cond_q & (funct[4:1] != 1010), so CMP never writes.
  - pc_write = cond_q & (rd == 15) & (funct[4:1] != 1010).
  - -> FETCH, retire.
- BRANCH:
  - alu_src_a = 0, alu_src_b = 01, result_src = 10, alu_op = 0, pc_write = cond_q.
  - -> FETCH, retire.
- Latencies with zero wait states:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Skipped: 2 cycles.
  - Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- retired counter: increments by 1 on each retire event and wraps modulo 2^CNT_W.
- Unreachable state encodings -> FETCH.
- Reset asserted mid-instruction: state returns to FETCH immediately (async). All write strobes deassert in the same time step, so no partial write.
- mem_ready is ignored in states without mem_req.

Decomposition:
- Package arm_mc_pkg holds:
  - state enum.
  - alu_src_b and result_src encodings as localparams.
  - OP_DP/OP_MEM/OP_BR constants.
  - FUNCT_CMP = 4'b1010.
- Sub-module mc_retire_counter (CNT_W, inc, reset) holds the counter. Everything else stays in one always_ff for state plus one always_comb for next state and outputs.

Test Plan:
- ADD imm (op = 00, funct = 101000, cond_ex = 1, mem_ready = 1 always) -> states FETCH, DECODE, EXECI, ALUWB; reg_write = 1 only in ALUWB; retired 0 -> 1 after 4 cycles.
- LDR with mem_ready low 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles with adr_src = 1, then MEMWB with result_src = 01, reg_write = 1; total 7 cycles.
- STR with cond_ex = 0 -> DECODE returns to FETCH; mem_write never 1; retired increments; 2 cycles total.
- CMP reg (funct = 010101) -> flag_write = 1 in EXECR; reg_write = 0 and pc_write = 0 in ALUWB.
- B followed by op = 11 -> pc_write = 1 in BRANCH; next instruction gives illegal = 1 pulse in DECODE and no retire increment.
- Reset asserted in MEMWRITE while mem_ready = 0 -> mem_write falls immediately, state = FETCH, retired = 0.
